// File: rtl/wt_dcache_rd_ctrl_par_if.sv
// Miss-unit and data-array bus of the dcache read controller.
// master = controller side, slave = miss unit / array side.
interface wt_dcache_rd_ctrl_par_if #(
    parameter int TagWidth     = 44,
    parameter int IdxWidth     = 8,
    parameter int OffWidth     = 4,
    parameter int SetAssoc     = 8,
    parameter int DataWidth    = 64,
    parameter int CacheIdWidth = 2
);
    logic                                  miss_req_o;
    logic                                  miss_ack_i;
    logic                                  miss_replay_i;
    logic                                  miss_rtrn_vld_i;
    logic [TagWidth+IdxWidth+OffWidth-1:0] miss_paddr_o;
    logic                                  miss_nc_o;
    logic [2:0]                            miss_size_o;
    logic [SetAssoc-1:0]                   miss_vld_bits_o;
    logic [CacheIdWidth-1:0]               miss_id_o;

    logic                                  rd_req_o;
    logic                                  rd_ack_i;
    logic [IdxWidth-1:0]                   rd_idx_o;
    logic [OffWidth-1:0]                   rd_off_o;
    logic [TagWidth-1:0]                   rd_tag_o;
    logic [DataWidth-1:0]                  rd_data_i;
    logic [SetAssoc-1:0]                   rd_vld_bits_i;
    logic [SetAssoc-1:0]                   rd_hit_oh_i;
    logic                                  wr_cl_vld_i;

    modport master (
        output miss_req_o, miss_paddr_o, miss_nc_o, miss_size_o, miss_vld_bits_o, miss_id_o,
        output rd_req_o, rd_idx_o, rd_off_o, rd_tag_o,
        input  miss_ack_i, miss_replay_i, miss_rtrn_vld_i,
        input  rd_ack_i, rd_data_i, rd_vld_bits_i, rd_hit_oh_i, wr_cl_vld_i
    );

    modport slave (
        input  miss_req_o, miss_paddr_o, miss_nc_o, miss_size_o, miss_vld_bits_o, miss_id_o,
        input  rd_req_o, rd_idx_o, rd_off_o, rd_tag_o,
        output miss_ack_i, miss_replay_i, miss_rtrn_vld_i,
        output rd_ack_i, rd_data_i, rd_vld_bits_i, rd_hit_oh_i, wr_cl_vld_i
    );
endinterface

// File: rtl/wt_dcache_rd_ctrl_par.sv
// Write-through dcache read-port controller: speculative array read, late tag, miss/replay/kill handling.
// Optional hit/miss performance counters are enabled with DCACHE_RD_CTRL_PERF_EN.
module wt_dcache_rd_ctrl_par #(
    parameter int TagWidth     = 44,
    parameter int IdxWidth     = 8,
    parameter int OffWidth     = 4,
    parameter int SetAssoc     = 8,
    parameter int DataWidth    = 64,
    parameter int RdTxId       = 1,
    parameter int MaxReplay    = 7,
    parameter int CntWidth     = 32,
    parameter int CacheIdWidth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cache_en_i,
    input  logic                 req_valid_i,
    output logic                 req_gnt_o,
    input  logic [IdxWidth-1:0]  req_idx_i,
    input  logic [OffWidth-1:0]  req_off_i,
    input  logic [1:0]           req_size_i,
    input  logic                 tag_valid_i,
    input  logic [TagWidth-1:0]  tag_i,
    input  logic                 nc_i,
    input  logic                 kill_i,
    output logic                 rsp_valid_o,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic                 rsp_err_o,
`ifdef DCACHE_RD_CTRL_PERF_EN
    output logic [CntWidth-1:0]  perf_hit_o,
    output logic [CntWidth-1:0]  perf_miss_o,
`endif
    wt_dcache_rd_ctrl_par_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, READ, MISS_REQ, MISS_WAIT, REPLAY_REQ, REPLAY_READ, KILL_ACK, KILL_WAIT
    } state_e;

    localparam int RpW = (MaxReplay < 1) ? 1 : $clog2(MaxReplay + 1);

    state_e              r_state, w_state_next;
    logic [IdxWidth-1:0] r_idx;
    logic [OffWidth-1:0] r_off;
    logic [1:0]          r_size;
    logic [TagWidth-1:0] r_tag;
    logic                r_nc;
    logic                r_rd_ack;
    logic                r_rd_req;
    logic [SetAssoc-1:0] r_vld_bits;
    logic [RpW-1:0]      r_replay_cnt;

    logic w_gnt, w_rd_req, w_miss_req, w_save_tag, w_hit;
    logic w_rsp_valid, w_rsp_err, w_replay_inc, w_nc_now, w_miss_nc, w_replay_full;

    assign w_replay_full = (r_replay_cnt == RpW'(MaxReplay));

    always_comb begin
        w_state_next = r_state;
        w_gnt        = 1'b0;
        w_rd_req     = 1'b0;
        w_miss_req   = 1'b0;
        w_save_tag   = 1'b0;
        w_hit        = 1'b0;
        w_rsp_valid  = 1'b0;
        w_rsp_err    = 1'b0;
        w_replay_inc = 1'b0;
        w_nc_now     = r_nc;
        case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    w_rd_req = 1'b1;
                    if (bus.rd_ack_i) begin
                        w_gnt        = 1'b1;
                        w_state_next = READ;
                    end
                end
            end
            READ, REPLAY_READ: begin
                w_rd_req = 1'b1;
                if (kill_i) begin
                    w_rsp_valid  = 1'b1;
                    w_state_next = IDLE;
                end else if (tag_valid_i || r_state == REPLAY_READ) begin
                    // a replayed read reuses the tag/nc captured on the first pass
                    if (r_state == READ) begin
                        w_save_tag = 1'b1;
                        w_nc_now   = nc_i;
                    end
                    if (bus.wr_cl_vld_i || !r_rd_ack) begin
                        if (w_replay_full) begin
                            w_rsp_valid  = 1'b1;
                            w_rsp_err    = 1'b1;
                            w_state_next = IDLE;
                        end else begin
                            w_replay_inc = 1'b1;
                            w_state_next = REPLAY_REQ;
                        end
                    end else if ((|bus.rd_hit_oh_i) && cache_en_i && !w_nc_now) begin
                        w_hit        = 1'b1;
                        w_rsp_valid  = 1'b1;
                        w_state_next = IDLE;
                        if (req_valid_i && bus.rd_ack_i) begin
                            w_gnt        = 1'b1;
                            w_state_next = READ;
                        end
                    end else begin
                        w_state_next = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                w_miss_req = 1'b1;
                if (kill_i) begin
                    w_rsp_valid  = 1'b1;
                    w_state_next = bus.miss_ack_i ? KILL_WAIT : KILL_ACK;
                end else if (bus.miss_replay_i) begin
                    if (w_replay_full) begin
                        w_rsp_valid  = 1'b1;
                        w_rsp_err    = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_replay_inc = 1'b1;
                        w_state_next = REPLAY_REQ;
                    end
                end else if (bus.miss_ack_i) begin
                    w_state_next = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (bus.miss_rtrn_vld_i) begin
                    w_rsp_valid  = 1'b1;
                    w_state_next = IDLE;
                end else if (kill_i) begin
                    w_rsp_valid  = 1'b1;
                    w_state_next = KILL_WAIT;
                end
            end
            REPLAY_REQ: begin
                w_rd_req = 1'b1;
                if (kill_i) begin
                    w_rsp_valid  = 1'b1;
                    w_state_next = IDLE;
                end else if (bus.rd_ack_i) begin
                    w_state_next = REPLAY_READ;
                end
            end
            KILL_ACK: begin
                w_miss_req = 1'b1;
                if (bus.miss_replay_i) begin
                    w_state_next = IDLE;
                end else if (bus.miss_ack_i) begin
                    w_state_next = KILL_WAIT;
                end
            end
            KILL_WAIT: begin
                if (bus.miss_rtrn_vld_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_tag        <= '0;
            r_nc         <= 1'b0;
            r_rd_ack     <= 1'b0;
            r_rd_req     <= 1'b0;
            r_vld_bits   <= '0;
            r_replay_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_rd_ack <= w_rd_req & bus.rd_ack_i;
            r_rd_req <= w_rd_req;
            if (r_rd_req) begin
                r_vld_bits <= bus.rd_vld_bits_i;
            end
            if (w_gnt) begin
                r_idx        <= req_idx_i;
                r_off        <= req_off_i;
                r_size       <= req_size_i;
                r_replay_cnt <= '0;
            end else if (w_replay_inc) begin
                r_replay_cnt <= r_replay_cnt + RpW'(1);
            end
            if (w_save_tag) begin
                r_tag <= tag_i;
                r_nc  <= nc_i;
            end
        end
    end

    // combinational outputs are forced quiet while reset is held
    assign w_miss_nc           = !cache_en_i || r_nc;
    assign req_gnt_o           = rst_ni & w_gnt;
    assign rsp_valid_o         = rst_ni & w_rsp_valid;
    assign rsp_err_o           = rst_ni & w_rsp_err;
    assign rsp_data_o          = (rst_ni & w_hit) ? bus.rd_data_i : '0;
    assign bus.rd_req_o        = rst_ni & w_rd_req;
    assign bus.rd_idx_o        = !rst_ni ? '0 : (w_gnt ? req_idx_i : r_idx);
    assign bus.rd_off_o        = !rst_ni ? '0 : (w_gnt ? req_off_i : r_off);
    assign bus.rd_tag_o        = !rst_ni ? '0 : (w_gnt ? tag_i : r_tag);
    assign bus.miss_req_o      = rst_ni & w_miss_req;
    assign bus.miss_paddr_o    = rst_ni ? {r_tag, r_idx, r_off} : '0;
    assign bus.miss_nc_o       = rst_ni & w_miss_nc;
    assign bus.miss_size_o     = (rst_ni & w_miss_nc) ? {1'b0, r_size} : 3'b111;
    assign bus.miss_vld_bits_o = rst_ni ? r_vld_bits : '0;
    assign bus.miss_id_o       = CacheIdWidth'(RdTxId);

`ifdef DCACHE_RD_CTRL_PERF_EN
    logic [CntWidth-1:0] r_perf_hit, r_perf_miss;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_perf_hit  <= '0;
            r_perf_miss <= '0;
        end else begin
            if (w_hit) begin
                r_perf_hit <= r_perf_hit + CntWidth'(1);
            end
            if (w_miss_req && bus.miss_ack_i) begin
                r_perf_miss <= r_perf_miss + CntWidth'(1);
            end
        end
    end

    assign perf_hit_o  = r_perf_hit;
    assign perf_miss_o = r_perf_miss;
`endif
endmodule

// File: tb/tb_wt_dcache_rd_ctrl_par.sv
// Scoreboard bench for wt_dcache_rd_ctrl_par: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_wt_dcache_rd_ctrl_par;
    localparam int TagW = 44;
    localparam int IdxW = 8;
    localparam int OffW = 4;
    localparam int DataW = 64;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             cache_en_i, req_valid_i, req_gnt_o, tag_valid_i, nc_i, kill_i;
    logic             rsp_valid_o, rsp_err_o;
    logic [IdxW-1:0]  req_idx_i;
    logic [OffW-1:0]  req_off_i;
    logic [1:0]       req_size_i;
    logic [TagW-1:0]  tag_i;
    logic [DataW-1:0] rsp_data_o;
`ifdef DCACHE_RD_CTRL_PERF_EN
    logic [31:0]      perf_hit_o, perf_miss_o;
`endif

    wt_dcache_rd_ctrl_par_if bus ();

    wt_dcache_rd_ctrl_par #(.MaxReplay(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cache_en_i(cache_en_i),
        .req_valid_i(req_valid_i), .req_gnt_o(req_gnt_o), .req_idx_i(req_idx_i),
        .req_off_i(req_off_i), .req_size_i(req_size_i), .tag_valid_i(tag_valid_i),
        .tag_i(tag_i), .nc_i(nc_i), .kill_i(kill_i), .rsp_valid_o(rsp_valid_o),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
`ifdef DCACHE_RD_CTRL_PERF_EN
        .perf_hit_o(perf_hit_o), .perf_miss_o(perf_miss_o),
`endif
        .bus(bus)
    );

    typedef struct { logic [63:0] data; logic chk_data; logic err; int cyc; } rsp_t;
    typedef struct { logic [55:0] paddr; logic nc; logic [2:0] size; logic [7:0] vld; } miss_t;

    rsp_t       rsp_q[$];
    miss_t      miss_q[$];
    logic [7:0] gnt_q[$];
    int errors = 0, checks = 0, cyc = 0, exp_hits = 0, exp_miss = 0;
    rsp_t       mon_r;
    miss_t      mon_m;
    logic [7:0] mon_g;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got 1 required 0 (cycle %0d)", name, cyc);
    endtask

    // monitor: pops expectations whenever the DUT presents a grant, response or miss handshake
    always @(negedge clk_i) begin
        if (req_gnt_o) begin
            if (gnt_q.size() == 0) unexpected("unexpected_gnt");
            else begin
                mon_g = gnt_q.pop_front();
                check("gnt_rd_idx", 64'(bus.rd_idx_o), 64'(mon_g));
            end
        end
        if (rsp_valid_o) begin
            if (rsp_q.size() == 0) unexpected("unexpected_rsp");
            else begin
                mon_r = rsp_q.pop_front();
                check("rsp_cycle", 64'(cyc), 64'(mon_r.cyc));
                check("rsp_err", 64'(rsp_err_o), 64'(mon_r.err));
                if (mon_r.chk_data) check("rsp_data", rsp_data_o, mon_r.data);
            end
        end
        if (bus.miss_req_o && bus.miss_ack_i) begin
            if (miss_q.size() == 0) unexpected("unexpected_miss");
            else begin
                mon_m = miss_q.pop_front();
                check("miss_paddr", 64'(bus.miss_paddr_o), 64'(mon_m.paddr));
                check("miss_nc", 64'(bus.miss_nc_o), 64'(mon_m.nc));
                check("miss_size", 64'(bus.miss_size_o), 64'(mon_m.size));
                check("miss_vld_bits", 64'(bus.miss_vld_bits_o), 64'(mon_m.vld));
                check("miss_id", 64'(bus.miss_id_o), 64'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_i = 0; tag_valid_i = 0; nc_i = 0; kill_i = 0;
        bus.rd_ack_i = 0; bus.miss_ack_i = 0; bus.miss_replay_i = 0;
        bus.miss_rtrn_vld_i = 0; bus.wr_cl_vld_i = 0; bus.rd_hit_oh_i = '0;
    endtask

    task automatic issue(input logic [7:0] idx, input logic [3:0] off, input logic [1:0] size);
        req_valid_i = 1; bus.rd_ack_i = 1;
        req_idx_i = idx; req_off_i = off; req_size_i = size;
        gnt_q.push_back(idx);
    endtask

    task automatic exp_rsp(input logic [63:0] data, input logic chk, input logic err);
        rsp_t r;
        r.data = data; r.chk_data = chk; r.err = err; r.cyc = cyc;
        rsp_q.push_back(r);
    endtask

    task automatic exp_miss_req(input logic [55:0] paddr, input logic nc, input logic [2:0] size,
                                input logic [7:0] vld);
        miss_t m;
        m.paddr = paddr; m.nc = nc; m.size = size; m.vld = vld;
        miss_q.push_back(m);
        exp_miss++;
    endtask

    task automatic tag_hit(input logic [43:0] tag, input logic [7:0] oh, input logic [63:0] data);
        tag_valid_i = 1; tag_i = tag; bus.rd_hit_oh_i = oh; bus.rd_data_i = data;
        exp_rsp(data, 1'b1, 1'b0);
        exp_hits++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [43:0] t;
        idle_inputs();
        cache_en_i = 0; req_valid_i = 1; bus.rd_ack_i = 1; req_idx_i = 8'h77;
        req_off_i = 4'h9; req_size_i = 2'd1; tag_i = 44'h123; bus.rd_data_i = '0;
        bus.rd_vld_bits_i = 8'hFF;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_req_gnt", 64'(req_gnt_o), 64'd0);
        check("rst_rd_req", 64'(bus.rd_req_o), 64'd0);
        check("rst_rd_idx", 64'(bus.rd_idx_o), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_miss_req", 64'(bus.miss_req_o), 64'd0);
        check("rst_miss_nc", 64'(bus.miss_nc_o), 64'd0);
        check("rst_miss_paddr", 64'(bus.miss_paddr_o), 64'd0);
        check("rst_miss_size", 64'(bus.miss_size_o), 64'd7);
        check("rst_miss_id", 64'(bus.miss_id_o), 64'd1);
        idle_inputs(); cache_en_i = 1; bus.rd_vld_bits_i = 8'h00; rst_ni = 1;
        tick();

        // single hit: response one cycle after grant
        issue(8'h12, 4'h3, 2'd3); tick();
        req_valid_i = 0; bus.rd_ack_i = 0;
        tag_hit(44'h0AB_CDEF_0123, 8'h04, 64'hDEAD_BEEF_0000_0001); tick();
        idle_inputs(); tick();

        // four back-to-back hitting requests
        issue(8'h20, 4'h0, 2'd3); tick();
        for (int i = 1; i <= 4; i++) begin
            tag_hit(44'h111 + 44'(i), 8'h01, 64'h100 + 64'(i));
            if (i < 4) issue(8'h20 + 8'(i), 4'h0, 2'd3);
            else begin req_valid_i = 0; bus.rd_ack_i = 0; end
            tick();
        end
        idle_inputs(); tick();

        // cacheable miss with delayed ack and return
        t = 44'h9_8765_4321;
        bus.rd_vld_bits_i = 8'hA5;
        issue(8'h34, 4'h5, 2'd3); tick();
        req_valid_i = 0; bus.rd_ack_i = 0; tag_valid_i = 1; tag_i = t; tick();
        tag_valid_i = 0; tick();
        bus.miss_ack_i = 1; exp_miss_req({t, 8'h34, 4'h5}, 1'b0, 3'b111, 8'hA5); tick();
        bus.miss_ack_i = 0; repeat (9) tick();
        bus.miss_rtrn_vld_i = 1; exp_rsp('0, 1'b0, 1'b0); tick();
        idle_inputs(); tick();

        // non-cacheable: hit vector ignored, size passed through
        t = 44'h5_5555_0000;
        issue(8'h56, 4'h2, 2'd2); tick();
        req_valid_i = 0; bus.rd_ack_i = 0; tag_valid_i = 1; tag_i = t; nc_i = 1;
        bus.rd_hit_oh_i = 8'h04; tick();
        tag_valid_i = 0; nc_i = 0; bus.rd_hit_oh_i = '0;
        bus.miss_ack_i = 1; exp_miss_req({t, 8'h56, 4'h2}, 1'b1, 3'b010, 8'hA5); tick();
        bus.miss_ack_i = 0; bus.miss_rtrn_vld_i = 1; exp_rsp('0, 1'b0, 1'b0); tick();
        idle_inputs(); tick();

        // kill in MISS_REQ without ack, replay releases KILL_ACK straight to IDLE
        issue(8'h60, 4'h0, 2'd3); tick();
        req_valid_i = 0; bus.rd_ack_i = 0; tag_valid_i = 1; tag_i = 44'h60; tick();
        tag_valid_i = 0; kill_i = 1; exp_rsp('0, 1'b0, 1'b0); tick();
        kill_i = 0; bus.miss_replay_i = 1; tick();
        bus.miss_replay_i = 0; issue(8'h61, 4'h1, 2'd3); tick();
        req_valid_i = 0; bus.rd_ack_i = 0;
        tag_hit(44'h61, 8'h02, 64'hCAFE_0061); tick();
        idle_inputs(); tick();

        // kill while waiting for the tag
        issue(8'h70, 4'h0, 2'd3); tick();
        req_valid_i = 0; bus.rd_ack_i = 0; kill_i = 1; exp_rsp('0, 1'b0, 1'b0); tick();
        idle_inputs(); tick();

        // kill and return in the same MISS_WAIT cycle -> one response, back to IDLE
        t = 44'hF_0000_00F0;
        issue(8'h80, 4'h1, 2'd3); tick();
        req_valid_i = 0; bus.rd_ack_i = 0; tag_valid_i = 1; tag_i = t; tick();
        tag_valid_i = 0; bus.miss_ack_i = 1; exp_miss_req({t, 8'h80, 4'h1}, 1'b0, 3'b111, 8'hA5); tick();
        bus.miss_ack_i = 0; kill_i = 1; bus.miss_rtrn_vld_i = 1; exp_rsp('0, 1'b0, 1'b0); tick();
        idle_inputs(); issue(8'h81, 4'h2, 2'd3); tick();
        req_valid_i = 0; bus.rd_ack_i = 0;
        tag_hit(44'h81, 8'h80, 64'h0081_0081); tick();
        idle_inputs(); tick();

        // starvation: collisions force 3 replays, the 4th attempt errors out
        issue(8'h90, 4'h0, 2'd3); bus.wr_cl_vld_i = 1; tick();
        req_valid_i = 0; tag_valid_i = 1; tag_i = 44'h90; bus.rd_hit_oh_i = 8'h04;
        repeat (6) tick();
        exp_rsp('0, 1'b0, 1'b1); tick();
        idle_inputs(); repeat (3) tick();

        check("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
        check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        check("miss_q_empty", 64'(miss_q.size()), 64'd0);
`ifdef DCACHE_RD_CTRL_PERF_EN
        check("perf_hit", 64'(perf_hit_o), 64'(exp_hits));
        check("perf_miss", 64'(perf_miss_o), 64'(exp_miss));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wt_dcache_rd_ctrl_par.md
WT_DCACHE_RD_CTRL_PAR -- requirements
Module: wt_dcache_rd_ctrl_par

Interface
REQ-001 SHALL have parameter TagWidth, default 44, meaning physical tag bits.
REQ-002 SHALL have parameter IdxWidth, default 8, meaning cacheline index bits.
REQ-003 SHALL have parameter OffWidth, default 4, meaning byte offset bits.
REQ-004 SHALL have parameter SetAssoc, default 8, meaning number of ways.
REQ-005 SHALL have parameter DataWidth, default 64, meaning read data bits.
REQ-006 SHALL have parameter RdTxId, default 1, meaning miss transaction ID; parameter MaxReplay, default 7, meaning replay limit; parameter CntWidth, default 32, meaning performance counter width.
REQ-007 Clock and reset SHALL be: clk_i in 1, the single clock; rst_ni in 1, reset that is synchronous and active-low.
REQ-008 Core-side ports SHALL be:
- cache_en_i in 1, cache enable.
- req_valid_i in 1, request.
- req_gnt_o out 1, request grant.
- req_idx_i in IdxWidth, request index.
- req_off_i in OffWidth, request offset.
- req_size_i in 2, request size.
- tag_valid_i in 1, tag valid.
- tag_i in TagWidth, late tag.
- nc_i in 1, non-cacheable flag, sampled with the tag.
- kill_i in 1, kill.
- rsp_valid_o out 1, response valid.
- rsp_data_o out DataWidth, response data.
- rsp_err_o out 1, response error.
REQ-009 Miss-side ports SHALL be:
- miss_req_o out 1, miss request.
- miss_ack_i in 1, miss acknowledge.
- miss_replay_i in 1, miss replay.
- miss_rtrn_vld_i in 1, miss return valid.
- miss_paddr_o out TagWidth+IdxWidth+OffWidth, miss address.
- miss_nc_o out 1, miss non-cacheable.
- miss_size_o out 3, miss size.
- miss_vld_bits_o out SetAssoc, valid bits at the missed index.
- miss_id_o out CACHE_ID_WIDTH, miss ID.
REQ-010 Array-side ports SHALL be:
- rd_req_o out 1, read request.
- rd_ack_i in 1, read acknowledge.
- rd_idx_o out IdxWidth, read index.
- rd_off_o out OffWidth, read offset.
- rd_tag_o out TagWidth, read tag.
- rd_data_i in DataWidth, read data.
- rd_vld_bits_i in SetAssoc, valid bits.
- rd_hit_oh_i in SetAssoc, one-hot hit.
- wr_cl_vld_i in 1, cacheline write collision.

Function
REQ-011 The FSM SHALL have states IDLE, READ, MISS_REQ, MISS_WAIT, REPLAY_REQ, REPLAY_READ, KILL_ACK, KILL_WAIT, encoded in 3 bits.
REQ-012 In IDLE, req_valid_i SHALL assert rd_req_o; rd_ack_i SHALL assert req_gnt_o in the same cycle, latch idx/off/size, and move to READ.
REQ-013 In READ, rd_req_o=1, and the following priority SHALL apply:
- kill_i -> IDLE with rsp_valid_o=1.
- Else tag_valid_i -> latch tag_i and nc_i.
- Then: wr_cl_vld_i or rd_ack not seen in the previous cycle -> REPLAY_REQ.
- Else |rd_hit_oh_i & cache_en_i & !nc -> hit.
- Else -> MISS_REQ.
REQ-014 On a hit, rsp_valid_o=1 and rsp_data_o=rd_data_i in the same cycle; a concurrent req_valid_i&rd_ack_i SHALL be granted (back-to-back, 1 request per cycle) and go to READ, else IDLE.
REQ-015 rd_vld_bits_i SHALL be captured one cycle after each rd_req_o and drive miss_vld_bits_o.
REQ-016 In MISS_REQ, miss_req_o=1, and the following priority SHALL apply:
- kill_i -> rsp_valid_o=1; miss_ack_i -> KILL_WAIT, else -> KILL_ACK.
- Else miss_replay_i -> REPLAY_REQ.
- Else miss_ack_i -> MISS_WAIT.
REQ-017 In MISS_WAIT, miss_rtrn_vld_i -> rsp_valid_o=1, -> IDLE; kill_i without a return -> rsp_valid_o=1, -> KILL_WAIT; kill_i and miss_rtrn_vld_i in the same cycle -> IDLE with one rsp_valid_o.
REQ-018 In KILL_ACK, miss_req_o=1; miss_replay_i -> IDLE; miss_ack_i -> KILL_WAIT. In KILL_WAIT, miss_rtrn_vld_i -> IDLE.
REQ-019 In REPLAY_REQ, rd_req_o=1; kill_i -> rsp_valid_o=1, -> IDLE; rd_ack_i -> REPLAY_READ. REPLAY_READ SHALL behave as READ using the latched tag.
REQ-020 A saturating replay counter SHALL increment on each entry to REPLAY_REQ and clear on grant.
- On entry attempt when count==MaxReplay: rsp_valid_o=1 and rsp_err_o=1 instead, -> IDLE.
- rsp_err_o=0 otherwise.
REQ-021 Miss outputs SHALL be set as follows:
- miss_paddr_o={tag_q,idx_q,off_q}.
- miss_nc_o=!cache_en_i|nc_q.
- miss_size_o={1'b0,size_q} if NC, else 3'b111.
- miss_id_o=RdTxId.
REQ-022 rd_idx_o/rd_off_o/rd_tag_o SHALL show the incoming value in the grant cycle and the latched value otherwise.
REQ-023 Undefined state encodings SHALL go to IDLE.

Reset
REQ-024 While rst_ni=0 at a clock edge, state SHALL be IDLE and all registers zero, including any in-flight request, with no response.
REQ-025 During reset, all outputs SHALL be 0 except miss_id_o=RdTxId and miss_size_o=3'b111.

Configuration
REQ-026 With DCACHE_RD_CTRL_PERF_EN defined:
- Add outputs perf_hit_o and perf_miss_o, each CntWidth wide.
- perf_hit_o SHALL increment on each hit response; perf_miss_o SHALL increment on each miss_req_o&miss_ack_i.
- Both SHALL wrap at 2^CntWidth and reset to 0.
- Without the macro, these ports and counters SHALL not exist.

Verification
REQ-027 Hit: req idx=0x12, rd_ack_i=1, next cycle tag_valid_i, rd_hit_oh_i=8'h04 -> rsp_valid_o=1 in cycle 2, data=rd_data_i.
REQ-028 Back-to-back: 4 consecutive hitting requests -> 4 grants and 4 responses in consecutive cycles.
REQ-029 Miss: rd_hit_oh_i=0, miss_ack_i after 2 cycles, miss_rtrn_vld_i after 10 -> miss_paddr_o correct, miss_size_o=3'b111, one response.
REQ-030 NC: nc_i=1, size=2 -> miss_nc_o=1, miss_size_o=3'b010.
REQ-031 Kill in MISS_REQ with miss_ack_i=0, then miss_replay_i -> rsp_valid_o once, KILL_ACK -> IDLE, no wait for a return.
REQ-032 Starvation: wr_cl_vld_i held high, MaxReplay=3 -> rsp_err_o=1 after 3 replays; with PERF_EN, perf_hit_o/perf_miss_o match the counts above.
